truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter N_INPUTS, default 2, SHALL set the stimulus vector width; legal range 1..4.
REQ-002 Parameter DWELL, default 25, SHALL set the clock cycles each vector is held; legal range 2..1023.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port start  input  1  SHALL request one full sweep when high in IDLE.
REQ-006 Port stim  output  N_INPUTS  SHALL drive the downstream gate's input1..inputN, with bit 0 mapped to the last input (LSB).
REQ-007 Port dut_out  input  1  SHALL carry the downstream gate's out.
REQ-008 Port busy  output  1  SHALL be high while a sweep is in progress.
REQ-009 Port vec_idx  output  N_INPUTS  SHALL give the index of the vector currently on stim.
REQ-010 Port done  output  1  SHALL pulse high for one cycle at the end of a sweep.

Function
REQ-011 The FSM SHALL have three states: IDLE, DRIVE and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL enter DRIVE with busy=1, stim=0, vec_idx=0 and dwell count=0 from edge k onward.
REQ-013 In DRIVE, the dwell counter SHALL increment each cycle from 0 to DWELL-1.
REQ-014 When dwell=DWELL-1 and vec_idx<2^N_INPUTS-1, stim and vec_idx SHALL increment by 1 and dwell SHALL clear.
REQ-015 When dwell=DWELL-1 and vec_idx=2^N_INPUTS-1, the FSM SHALL enter DONE, with stim=0, vec_idx=0 and busy=0.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Each vector SHALL be held exactly DWELL cycles, and a sweep SHALL occupy exactly 2^N_INPUTS*DWELL cycles with busy=1.
REQ-018 start SHALL be ignored in DRIVE and DONE; there is no queuing of requests.
REQ-019 start held high continuously SHALL produce back-to-back sweeps, each separated by one DONE cycle and one IDLE cycle.
REQ-020 vec_idx increments SHALL not wrap within a sweep; the counter width SHALL be N_INPUTS+1 internally, so the last-vector compare is exact.
REQ-021 dut_out SHALL be sampled only on the cycle where dwell=DWELL-1, which gives the gate settle time.

Reset
REQ-022 rst_n=0 SHALL force IDLE immediately: stim=0, vec_idx=0, busy=0, done=0, dwell=0, plus any check counters cleared.
REQ-023 A reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release, the block SHALL wait for a new start.

Configuration
REQ-024 With macro TT_SEQ_CHECK_EN defined, the block SHALL add:
- input expected [2^N_INPUTS-1:0], where bit i is the expected out for vector i;
- output mismatch_cnt [N_INPUTS:0];
- output pass [1].
REQ-025 With TT_SEQ_CHECK_EN defined:
- mismatch_cnt SHALL clear on sweep start;
- mismatch_cnt SHALL increment at each sample (REQ-021) where dut_out != expected[vec_idx];
- pass SHALL be valid with done and equal 1 iff mismatch_cnt=0.
REQ-026 With TT_SEQ_CHECK_EN undefined, the ports and logic in REQ-024/025 SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 A shared package tt_seq_pkg SHALL hold the state enum (IDLE, DRIVE, DONE), the default DWELL, and the N_INPUTS maximum.
REQ-028 The dwell counter SHALL be a sub-module, dwell_counter, with clear/enable inputs and a terminal-count output.

Verification
REQ-029 N_INPUTS=2, DWELL=4, start pulsed at edge 0 -> stim SHALL be:
- 00 for edges 0-3, 01 for 4-7, 10 for 8-11, 11 for 12-15;
- done=1 in cycle 16, and busy=0 from 16.
REQ-030 start pulsed again during cycle 6 of a sweep -> there SHALL be no effect: single sweep, one done pulse.
REQ-031 rst_n low at cycle 9 of the REQ-029 sweep -> stim=0 and busy=0 asynchronously, with no done pulse; the next start SHALL restart from vector 00.
REQ-032 TT_SEQ_CHECK_EN, downstream gate AND, expected=4'b1000 -> mismatch_cnt=0 and pass=1 at done.
REQ-033 TT_SEQ_CHECK_EN, downstream gate OR, expected=4'b1000 -> mismatch_cnt=2 and pass=0 at done.
REQ-034 N_INPUTS=3, DWELL=2, start held high -> vectors 000..111, done, then a second sweep starting 2 cycles after done went high, with a 16-cycle busy window each.

Source files
------------

// File: rtl/tt_seq_pkg.sv
// Shared types and limits for the truth-table sequencer and its dwell counter.
package tt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } tt_state_e;

  localparam int TT_DWELL_DEFAULT = 25;
  localparam int TT_N_INPUTS_MAX  = 4;

endpackage

// File: rtl/dwell_counter.sv
// Counts the cycles a stimulus vector has been held; tc marks the last cycle of the dwell.
module dwell_counter #(
  parameter int DWELL = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] LAST = W'(DWELL - 1);

  logic [W-1:0] r_count;

  // clr has priority so the count restarts at 0 on the cycle after tc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign tc = en && (r_count == LAST);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input combination of a downstream gate, holding each for DWELL cycles.
// Optional self-check of the gate output against a truth table: define TT_SEQ_CHECK_EN.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int DWELL    = TT_DWELL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [N_INPUTS-1:0]   stim,
  input  logic                  dut_out,
  output logic                  busy,
  output logic [N_INPUTS-1:0]   vec_idx,
  output logic                  done
`ifdef TT_SEQ_CHECK_EN
  ,
  input  logic [(1<<N_INPUTS)-1:0] expected,
  output logic [N_INPUTS:0]        mismatch_cnt,
  output logic                     pass
`endif
);

  // One extra bit keeps the last-vector compare exact and the index from wrapping
  localparam logic [N_INPUTS:0] LAST_VEC = {1'b0, {N_INPUTS{1'b1}}};

  tt_state_e             r_state;
  logic [N_INPUTS:0]     r_vec;
  logic                  w_drive;
  logic                  w_tc;
  logic                  w_last;

  assign w_drive = (r_state == ST_DRIVE);
  assign w_last  = w_tc && (r_vec == LAST_VEC);

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!w_drive || w_tc),
    .en    (w_drive),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_vec <= '0;
          if (start) r_state <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_vec   <= '0;
          end else if (w_tc) begin
            r_vec <= r_vec + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
        end
      endcase
    end
  end

  assign stim    = r_vec[N_INPUTS-1:0];
  assign vec_idx = r_vec[N_INPUTS-1:0];
  assign busy    = w_drive;
  assign done    = (r_state == ST_DONE);

`ifdef TT_SEQ_CHECK_EN
  logic [N_INPUTS:0] r_mis;

  // The gate output is only trusted on the final dwell cycle, after it has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_mis <= '0;
    end else if (w_tc && (dut_out != expected[r_vec[N_INPUTS-1:0]])) begin
      r_mis <= r_mis + 1'b1;
    end
  end

  assign mismatch_cnt = r_mis;
  assign pass         = done && (r_mis == '0);
`else
  logic w_unused_dut_out;
  assign w_unused_dut_out = dut_out;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: 2-input/DWELL=4 and 3-input/DWELL=2 instances.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       start_a, start_b;
  logic [1:0] stim_a, vec_a;
  logic [2:0] stim_b, vec_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       dut_out_a, dut_out_b;
  logic       gate_or;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cnt_a = 0;
  int         d0;

`ifdef TT_SEQ_CHECK_EN
  logic [3:0] expected_a;
  logic [7:0] expected_b;
  logic [2:0] mis_a;
  logic [3:0] mis_b;
  logic       pass_a, pass_b;
`endif

  always #5 clk = ~clk;

  // Downstream gate model: 2-input AND or OR
  assign dut_out_a = gate_or ? (stim_a[1] | stim_a[0]) : (stim_a[1] & stim_a[0]);
  assign dut_out_b = 1'b0;

  always @(posedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;

  truth_table_sequencer #(.N_INPUTS(2), .DWELL(4)) u_dut_a (
    .clk (clk), .rst_n (rst_a), .start (start_a), .stim (stim_a),
    .dut_out (dut_out_a), .busy (busy_a), .vec_idx (vec_a), .done (done_a)
`ifdef TT_SEQ_CHECK_EN
    , .expected (expected_a), .mismatch_cnt (mis_a), .pass (pass_a)
`endif
  );

  truth_table_sequencer #(.N_INPUTS(3), .DWELL(2)) u_dut_b (
    .clk (clk), .rst_n (rst_b), .start (start_b), .stim (stim_b),
    .dut_out (dut_out_b), .busy (busy_b), .vec_idx (vec_b), .done (done_b)
`ifdef TT_SEQ_CHECK_EN
    , .expected (expected_b), .mismatch_cnt (mis_b), .pass (pass_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0; gate_or = 1'b0;
`ifdef TT_SEQ_CHECK_EN
    expected_a = 4'b1000;
    expected_b = 8'h00;
`endif
    tick(); tick();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_stim", 32'(stim_a), 32'd0);
    chk("rst_vec", 32'(vec_a), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_a), 32'd0);

    // Basic sweep, AND gate
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 0; e < 16; e++) begin
      chk("sw_stim", 32'(stim_a), 32'(e / 4));
      chk("sw_vec", 32'(vec_a), 32'(e / 4));
      chk("sw_busy", 32'(busy_a), 32'd1);
      chk("sw_done", 32'(done_a), 32'd0);
      tick();
    end
    chk("end_done", 32'(done_a), 32'd1);
    chk("end_busy", 32'(busy_a), 32'd0);
    chk("end_stim", 32'(stim_a), 32'd0);
`ifdef TT_SEQ_CHECK_EN
    chk("and_mis", 32'(mis_a), 32'd0);
    chk("and_pass", 32'(pass_a), 32'd1);
`endif
    tick();
    chk("post_done", 32'(done_a), 32'd0);
    chk("post_busy", 32'(busy_a), 32'd0);

    // start pulsed mid-sweep has no effect; OR gate
    gate_or = 1'b1;
    d0 = done_cnt_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (6) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ign_busy", 32'(busy_a), 32'd1);
    chk("ign_stim", 32'(stim_a), 32'd1);
    repeat (9) tick();
    chk("ign_done", 32'(done_a), 32'd1);
`ifdef TT_SEQ_CHECK_EN
    chk("or_mis", 32'(mis_a), 32'd2);
    chk("or_pass", 32'(pass_a), 32'd0);
`endif
    repeat (5) tick();
    chk("ign_onedone", 32'(done_cnt_a - d0), 32'd1);
    chk("ign_idle", 32'(busy_a), 32'd0);

    // Reset mid-sweep aborts with no done pulse
    gate_or = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    chk("ab_stim", 32'(stim_a), 32'd2);
    d0 = done_cnt_a;
    #2 rst_a = 1'b0;
    #1;
    chk("ab_stim0", 32'(stim_a), 32'd0);
    chk("ab_busy0", 32'(busy_a), 32'd0);
    chk("ab_vec0", 32'(vec_a), 32'd0);
    tick(); tick(); tick();
    rst_a = 1'b1;
    repeat (20) tick();
    chk("ab_wait", 32'(busy_a), 32'd0);
    chk("ab_nodone", 32'(done_cnt_a - d0), 32'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rs_stim", 32'(stim_a), 32'd0);
    chk("rs_busy", 32'(busy_a), 32'd1);
    repeat (4) tick();
    chk("rs_stim1", 32'(stim_a), 32'd1);
    repeat (12) tick();
    chk("rs_done", 32'(done_a), 32'd1);
`ifdef TT_SEQ_CHECK_EN
    chk("rs_mis", 32'(mis_a), 32'd0);
    chk("rs_pass", 32'(pass_a), 32'd1);
`endif

    // start held high on the 3-input instance: back-to-back sweeps
    start_b = 1'b1;
    tick();
    for (int e = 0; e < 16; e++) begin
      chk("b2b_stim", 32'(stim_b), 32'(e / 2));
      chk("b2b_busy", 32'(busy_b), 32'd1);
      tick();
    end
    chk("b2b_done", 32'(done_b), 32'd1);
    chk("b2b_nbusy", 32'(busy_b), 32'd0);
    tick();
    chk("b2b_idle_done", 32'(done_b), 32'd0);
    chk("b2b_idle_busy", 32'(busy_b), 32'd0);
    tick();
    chk("b2b_restart", 32'(busy_b), 32'd1);
    chk("b2b_restim", 32'(stim_b), 32'd0);
    start_b = 1'b0;
    for (int e = 1; e < 16; e++) begin
      tick();
      chk("b2b_busy2", 32'(busy_b), 32'd1);
    end
    tick();
    chk("b2b_done2", 32'(done_b), 32'd1);
`ifdef TT_SEQ_CHECK_EN
    chk("b2b_pass", 32'(pass_b), 32'd1);
`endif
    tick(); tick();
    chk("b2b_stop", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
